// File: rtl/point_sub.sv
// point_sub: affine R = P - Q over secp256k1 with a shared multiplier and one-cycle FSM steps.
// Defining POINT_SUB_ADD_MODE_EN adds input op (1: P - Q, 0: P + Q).

package point_sub_pkg;
   localparam logic [255:0] P      = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [32:0]  FOLD_C = 33'h1_0000_03D1;

   function automatic logic [255:0] fp_sub(input logic [255:0] a, input logic [255:0] b);
      logic [256:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[256] ? (d[255:0] + P) : d[255:0];
   endfunction

   // 2^256 == 2^32 + 977 (mod p): fold the high half down twice, then one conditional subtract.
   function automatic logic [255:0] fp_mul(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] t;
      logic [289:0] f1;
      logic [256:0] f2;
      logic [255:0] f3;
      t  = {256'd0, a} * {256'd0, b};
      f1 = {34'd0, t[255:0]} + {34'd0, t[511:256]} * {257'd0, FOLD_C};
      f2 = {1'b0, f1[255:0]} + {223'd0, f1[289:256]} * {224'd0, FOLD_C};
      f3 = f2[255:0] + (f2[256] ? {223'd0, FOLD_C} : 256'd0);
      return (f3 >= P) ? (f3 - P) : f3;
   endfunction

   function automatic logic [255:0] fp_inv(input logic [255:0] a);
      logic [255:0] r;
      logic [255:0] e;
      r = 256'd1;
      e = P - 256'd2;
      for (int i = 0; i < 256; i++) begin
         r = fp_mul(r, r);
         r = e[255] ? fp_mul(r, a) : r;
         e = {e[254:0], 1'b0};
      end
      return r;
   endfunction
endpackage

module mod_sub (
   input  logic [255:0] a_i,
   input  logic [255:0] b_i,
   output logic [255:0] r_o
);
   assign r_o = point_sub_pkg::fp_sub(a_i, b_i);
endmodule

module mod_mult (
   input  logic [255:0] a_i,
   input  logic [255:0] b_i,
   output logic [255:0] r_o
);
   assign r_o = point_sub_pkg::fp_mul(a_i, b_i);
endmodule

module mod_inv (
   input  logic [255:0] a_i,
   output logic [255:0] r_o
);
   assign r_o = point_sub_pkg::fp_inv(a_i);
endmodule

module point_sub (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] x1,
   input  logic [255:0] y1,
   input  logic [255:0] x2,
   input  logic [255:0] y2,
`ifdef POINT_SUB_ADD_MODE_EN
   input  logic         op,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] x3,
   output logic [255:0] y3,
   output logic         err
);
   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_NEG  = 4'd1, S_DIFF = 4'd2, S_INV  = 4'd3, S_LAM  = 4'd4,
      S_SQ   = 4'd5, S_SUBX = 4'd6, S_MULY = 4'd7, S_SUBY = 4'd8, S_DONE = 4'd9
   } state_t;

   state_t       state_q;
   logic         start_q;
   logic [255:0] x1_q, y1_q, x2_q, y2_q;
   logic [255:0] y2n_q, dx_q, dy_q, inv_q, lam_q, mul_q, xr_q;
   logic [255:0] x3_q, y3_q;
   logic         err_q, out_valid_q;
   logic         neg_en_s;

   logic [255:0] sub0_a_s, sub0_b_s, sub0_r_s;
   logic [255:0] sub1_a_s, sub1_b_s, sub1_r_s;
   logic [255:0] mul_a_s, mul_b_s, mul_r_s;
   logic [255:0] inv_s;

`ifdef POINT_SUB_ADD_MODE_EN
   logic op_q;
   assign neg_en_s = op_q;
`else
   assign neg_en_s = 1'b1;
`endif

   mod_sub  u_sub0 (.a_i(sub0_a_s), .b_i(sub0_b_s), .r_o(sub0_r_s));
   mod_sub  u_sub1 (.a_i(sub1_a_s), .b_i(sub1_b_s), .r_o(sub1_r_s));
   mod_mult u_mult (.a_i(mul_a_s),  .b_i(mul_b_s),  .r_o(mul_r_s));
   mod_inv  u_inv  (.a_i(dx_q),     .r_o(inv_s));

   // Operands of the first subtractor, selected by the current step.
   always_comb begin
      sub0_a_s = 256'd0;
      sub0_b_s = 256'd0;
      case (state_q)
         S_NEG:  begin sub0_a_s = 256'd0; sub0_b_s = y2_q;  end
         S_DIFF: begin sub0_a_s = x2_q;   sub0_b_s = x1_q;  end
         S_SUBX: begin sub0_a_s = mul_q;  sub0_b_s = x1_q;  end
         S_MULY: begin sub0_a_s = x1_q;   sub0_b_s = xr_q;  end
         S_SUBY: begin sub0_a_s = mul_q;  sub0_b_s = y1_q;  end
         default: begin sub0_a_s = 256'd0; sub0_b_s = 256'd0; end
      endcase
   end

   // Second subtractor and shared multiplier; these may chain off the first subtractor.
   always_comb begin
      sub1_a_s = 256'd0;
      sub1_b_s = 256'd0;
      mul_a_s  = 256'd0;
      mul_b_s  = 256'd0;
      case (state_q)
         S_DIFF: begin sub1_a_s = y2n_q;    sub1_b_s = y1_q; end
         S_SUBX: begin sub1_a_s = sub0_r_s; sub1_b_s = x2_q; end
         S_LAM:  begin mul_a_s  = dy_q;     mul_b_s  = inv_q; end
         S_SQ:   begin mul_a_s  = lam_q;    mul_b_s  = lam_q; end
         S_MULY: begin mul_a_s  = lam_q;    mul_b_s  = sub0_r_s; end
         default: begin sub1_a_s = 256'd0; sub1_b_s = 256'd0; end
      endcase
   end

   // Operands are captured on the accepting edge; the sequence starts from them one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         x1_q        <= 256'd0;
         y1_q        <= 256'd0;
         x2_q        <= 256'd0;
         y2_q        <= 256'd0;
         y2n_q       <= 256'd0;
         dx_q        <= 256'd0;
         dy_q        <= 256'd0;
         inv_q       <= 256'd0;
         lam_q       <= 256'd0;
         mul_q       <= 256'd0;
         xr_q        <= 256'd0;
         x3_q        <= 256'd0;
         y3_q        <= 256'd0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef POINT_SUB_ADD_MODE_EN
         op_q        <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_q) begin
                  start_q <= 1'b0;
                  state_q <= S_NEG;
               end else if (in_valid) begin
                  x1_q    <= x1;
                  y1_q    <= y1;
                  x2_q    <= x2;
                  y2_q    <= y2;
`ifdef POINT_SUB_ADD_MODE_EN
                  op_q    <= op;
`endif
                  start_q <= 1'b1;
               end
            end
            S_NEG: begin
               y2n_q   <= neg_en_s ? sub0_r_s : y2_q;
               state_q <= S_DIFF;
            end
            S_DIFF: begin
               if (x1_q == x2_q) begin
                  x3_q        <= 256'd0;
                  y3_q        <= 256'd0;
                  err_q       <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  dx_q    <= sub0_r_s;
                  dy_q    <= sub1_r_s;
                  state_q <= S_INV;
               end
            end
            S_INV:  begin inv_q <= inv_s;    state_q <= S_LAM;  end
            S_LAM:  begin lam_q <= mul_r_s;  state_q <= S_SQ;   end
            S_SQ:   begin mul_q <= mul_r_s;  state_q <= S_SUBX; end
            S_SUBX: begin xr_q  <= sub1_r_s; state_q <= S_MULY; end
            S_MULY: begin mul_q <= mul_r_s;  state_q <= S_SUBY; end
            S_SUBY: begin
               x3_q        <= xr_q;
               y3_q        <= sub0_r_s;
               err_q       <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = rst_n & (state_q == S_IDLE) & ~start_q;
   assign out_valid = out_valid_q;
   assign x3        = x3_q;
   assign y3        = y3_q;
   assign err       = err_q;

endmodule

// File: tb/tb_point_sub.sv
// Bench for point_sub: modular-arithmetic reference model, per-cycle output monitor, directed vectors.
module tb_point_sub;
   localparam logic [255:0] P   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [255:0] GX  = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
   localparam logic [255:0] GY  = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
   localparam logic [255:0] G2X = 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
   localparam logic [255:0] G2Y = 256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
   localparam logic [255:0] G3X = 256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9;
   localparam logic [255:0] G3Y = 256'h388F7B0F_632DE814_0FE337E6_2A37F356_6500A999_34C2231B_6CB9FD75_84B8E672;
   localparam logic [255:0] NEG_G2Y = 256'hE51E9701_59C23CC6_5C3A7BE6_B99315110_809CD9A_CD992F1E_DC9BCE55_AF301705;

   logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, err, op_s;
   logic [255:0] x1, y1, x2, y2, x3, y3;
   int n_cmp = 0, n_bad = 0, cyc = 0, last_acc = 0, last_hs = 0;

   typedef struct {
      logic [255:0] x;
      logic [255:0] y;
      logic         e;
      int           acc;
      int           lat;
   } exp_t;
   exp_t q[$];

   point_sub dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2),
`ifdef POINT_SUB_ADD_MODE_EN
      .op(op_s),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .x3(x3), .y3(y3), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
      return 256'((({256'd0, a} * {256'd0, b}) % {256'd0, P}));
   endfunction

   function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
      return 256'((({1'b0, a} + {1'b0, P} - {1'b0, b}) % {1'b0, P}));
   endfunction

   function automatic logic [255:0] finv(input logic [255:0] a);
      logic [255:0] r;
      logic [255:0] e;
      r = 256'd1;
      e = P - 256'd2;
      repeat (256) begin
         r = fmul(r, r);
         if (e[255]) r = fmul(r, a);
         e = e << 1;
      end
      return r;
   endfunction

   task automatic model(input logic [255:0] a1, input logic [255:0] b1, input logic [255:0] a2,
                        input logic [255:0] b2, input logic o,
                        output logic [255:0] rx, output logic [255:0] ry, output logic re);
      logic [255:0] yq, lam;
      if (a1 == a2) begin
         rx = 256'd0; ry = 256'd0; re = 1'b1;
      end else begin
         yq  = o ? fsub(256'd0, b2) : b2;
         lam = fmul(fsub(yq, b1), finv(fsub(a2, a1)));
         rx  = fsub(fsub(fmul(lam, lam), a1), a2);
         ry  = fsub(fmul(lam, fsub(a1, rx)), b1);
         re  = 1'b0;
      end
   endtask

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_i(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: records accepted operand sets with model results, checks every valid output cycle.
   initial begin
      exp_t ent;
      logic seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            seen = 1'b0;
         end else begin
            if (in_valid && in_ready) begin
               model(x1, y1, x2, y2, op_s, ent.x, ent.y, ent.e);
               ent.acc  = cyc + 1;
               ent.lat  = ent.e ? 3 : 9;
               last_acc = cyc + 1;
               q.push_back(ent);
            end
            if (out_valid) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL stray_out: out_valid=1 expected 0");
               end else begin
                  chk("mon_x3", x3, q[0].x);
                  chk("mon_y3", y3, q[0].y);
                  chk("mon_err", {255'd0, err}, {255'd0, q[0].e});
                  chk("mon_in_ready_busy", {255'd0, in_ready}, 256'd0);
                  if (!seen) begin
                     chk_i("mon_latency", cyc - q[0].acc, q[0].lat);
                     seen = 1'b1;
                  end
                  if (out_ready) begin
                     void'(q.pop_front());
                     seen    = 1'b0;
                     last_hs = cyc + 1;
                  end
               end
            end
         end
      end
   end

   task automatic drive(input logic [255:0] a1, input logic [255:0] b1, input logic [255:0] a2,
                        input logic [255:0] b2, input logic o);
      x1 = a1; y1 = b1; x2 = a2; y2 = b2; op_s = o;
      in_valid = 1'b1;
   endtask

   task automatic wait_accept(input logic hold);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_accept: in_ready=0 expected 1 within 60 cycles");
      end
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic send(input logic [255:0] a1, input logic [255:0] b1, input logic [255:0] a2,
                       input logic [255:0] b2, input logic o, input logic hold);
      @(posedge clk);
      #1;
      drive(a1, b1, a2, b2, o);
      wait_accept(hold);
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_out: out_valid=0 expected 1 within 30 cycles");
      end
      #1;
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      r = 256'd0;
      repeat (8) r = {r[223:0], 32'($urandom())};
      r[255] = 1'b0;
      return r;
   endfunction

   initial begin
      logic [255:0] rx, ry;
      logic         re;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_s = 1'b1;
      x1 = 256'd0; y1 = 256'd0; x2 = 256'd0; y2 = 256'd0;

      // Pin the reference model with hand-known points.
      chk("pin_sub_wrap", fsub(256'd5, 256'd9),
          256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2B);
      chk("pin_neg_zero", fsub(256'd0, 256'd0), 256'd0);
      chk("pin_neg_g2y", fsub(256'd0, G2Y), NEG_G2Y);
      model(G3X, G3Y, GX, GY, 1'b1, rx, ry, re);
      chk("pin_3g_g_x", rx, G2X);
      chk("pin_3g_g_y", ry, G2Y);
      model(GX, GY, G2X, NEG_G2Y, 1'b1, rx, ry, re);
      chk("pin_g_neg2g_x", rx, G3X);
      chk("pin_g_neg2g_y", ry, G3Y);
      model(GX, GY, GX, GY, 1'b1, rx, ry, re);
      chk("pin_degenerate_err", {255'd0, re}, 256'd1);

      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
      chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
      chk("rst_x3", x3, 256'd0);
      chk("rst_y3", y3, 256'd0);
      chk("rst_err", {255'd0, err}, 256'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("rst_release_in_ready", {255'd0, in_ready}, 256'd1);

      // 3G - G = 2G
      send(G3X, G3Y, GX, GY, 1'b1, 1'b0);
      wait_out();
      chk("a_x3", x3, G2X);
      chk("a_y3", y3, G2Y);
      chk("a_err", {255'd0, err}, 256'd0);

      // G - G: degenerate
      send(GX, GY, GX, GY, 1'b1, 1'b0);
      wait_out();
      chk("b_err", {255'd0, err}, 256'd1);
      chk("b_x3", x3, 256'd0);
      chk("b_y3", y3, 256'd0);

      // Consumer stalls for six cycles; 2G - G = G
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(G2X, G2Y, GX, GY, 1'b1, 1'b0);
      wait_out();
      chk("c_x3", x3, GX);
      chk("c_y3", y3, GY);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("c_idle_in_ready", {255'd0, in_ready}, 256'd1);
      chk("c_idle_out_valid", {255'd0, out_valid}, 256'd0);

      // Reset while in LAM, then a clean 3G - G
      send(G3X, G3Y, GX, GY, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("d_rst_out_valid", {255'd0, out_valid}, 256'd0);
      chk("d_rst_x3", x3, 256'd0);
      chk("d_rst_y3", y3, 256'd0);
      chk("d_rst_err", {255'd0, err}, 256'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(G3X, G3Y, GX, GY, 1'b1, 1'b0);
      wait_out();
      chk("d_x3", x3, G2X);
      chk("d_y3", y3, G2Y);

      // Second operand set held on in_valid while busy: G - (-2G) = 3G
      send(G2X, G2Y, GX, GY, 1'b1, 1'b1);
      drive(GX, GY, G2X, NEG_G2Y, 1'b1);
      wait_accept(1'b0);
      chk_i("e_accept_after_handshake", last_acc - last_hs, 1);
      wait_out();
      chk("e_x3", x3, G3X);
      chk("e_y3", y3, G3Y);

      // Boundary operands: y2 == 0, wrap-around differences, and random values
      send(256'd5, 256'd7, 256'd9, 256'd0, 1'b1, 1'b0);
      wait_out();
      send(P - 256'd1, P - 256'd1, 256'd1, P - 256'd1, 1'b1, 1'b0);
      wait_out();
      for (int i = 0; i < 2; i++) begin
         send(rnd256(), rnd256(), rnd256(), rnd256(), 1'b1, 1'b0);
         wait_out();
      end

`ifdef POINT_SUB_ADD_MODE_EN
      // Add mode: G + 2G = 3G
      send(GX, GY, G2X, G2Y, 1'b0, 1'b0);
      wait_out();
      chk("g_add_x3", x3, G3X);
      chk("g_add_y3", y3, G3Y);
`endif

      repeat (5) @(posedge clk);
      #1 chk_i("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/point_sub.md
POINT_SUB -- requirements
Module: point_sub

Interface
REQ-001 clk  input  1  Single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  Reset, asynchronous and active-low.
REQ-003 in_valid  input  1  Operand set x1, y1, x2, y2 (and op, when configured) is valid.
REQ-004 in_ready  output  1  Block accepts an operand set; high only in IDLE and only while rst_n is high.
REQ-005 x1, y1  input  256 each  Affine point P over secp256k1.
REQ-006 x2, y2  input  256 each  Affine point Q over secp256k1.
REQ-007 out_valid  output  1  Result x3, y3, err is valid.
REQ-008 out_ready  input  1  Consumer accepts the result.
REQ-009 x3, y3  output  256 each  Affine result R = P - Q mod p, where p = 2^256 - 2^32 - 977.
REQ-010 err  output  1  Degenerate case, x1 == x2: result not computed.

Function
REQ-011 An input is accepted on a rising edge with in_valid & in_ready; all operands are registered on that edge.
REQ-012 -Q is formed as (x2, (p - y2) mod p); y2 == 0 yields 0, not p.
REQ-013 R is the chord sum of P and -Q:
- lam = (y2n - y1) * inv(x2 - x1)
- x3 = lam^2 - x1 - x2
- y3 = lam*(x1 - x3) - y1
- All operations mod p, using the existing mod_sub, mod_mult and mod_inv units.
REQ-014 One mod_mult instance is shared across the LAM, SQ and MULY states; every intermediate is registered.
REQ-015 FSM states, one cycle each, entered in order after acceptance: IDLE -> NEG -> DIFF -> INV -> LAM -> SQ -> SUBX -> MULY -> SUBY -> DONE.
REQ-016 out_valid rises exactly 9 edges after the accepting edge, on the edge leaving SUBY.
REQ-017 In DIFF, if x1 == x2, the FSM goes directly to DONE with err=1, x3=0 and y3=0; out_valid rises 3 edges after acceptance.
REQ-018 In DONE, out_valid, x3, y3 and err are held stable until out_valid & out_ready; on that edge the FSM returns to IDLE and out_valid falls.
REQ-019 in_ready is low in every state other than IDLE; in_valid is ignored while busy.
REQ-020 No input acceptance occurs on the same edge as an output handshake.
REQ-021 Operands are required to be < p; results for operands >= p are unspecified.

Reset
REQ-022 On rst_n low, immediately and asynchronously:
- state = IDLE
- out_valid = 0, err = 0, x3 = 0, y3 = 0
- all intermediate registers = 0
REQ-023 Reset mid-operation abandons the computation; no out_valid is produced for the abandoned operand set.
REQ-024 The first edge with rst_n high may accept a new operand set.

Configuration
REQ-025 Macro POINT_SUB_ADD_MODE_EN.
- Defined: a 1-bit input op is present; op=1 computes P - Q; op=0 skips negation and computes P + Q; op is registered with the operands; latency is unchanged and NEG still occupies one cycle.
- Not defined: port op is absent and the block always subtracts.

Verification
REQ-026 P = 3G, Q = G (SEC2 generator constants) -> x3,y3 = 2G (x = C6047F94...5C709EE5), err=0, out_valid exactly 9 cycles after accept.
REQ-027 P = G, Q = G -> err=1, x3 = y3 = 0, out_valid 3 cycles after accept.
REQ-028 Hold out_ready low for 6 cycles after out_valid -> x3, y3, err stable and in_ready=0 throughout; IDLE is reached one cycle after out_ready rises.
REQ-029 Pulse rst_n low while in LAM -> out_valid=0 and outputs zero immediately; a following 3G - G completes correctly with no stale output.
REQ-030 Drive in_valid continuously with a second operand set while busy -> it is accepted only on the first IDLE edge after the output handshake, and both results are correct in order.
REQ-031 With POINT_SUB_ADD_MODE_EN defined, op=0, P = G, Q = 2G -> x3,y3 = 3G (x = F9308A01...BCE036F9), 9-cycle latency.
